writeback_unit: RTL and testbench

Single write-port front end for the 32×32 integer register file. Arbitrates ALU results and returning load data onto the register file's one write port (`rdi`, `write_data`, `reg_write`). Tracks outstanding loads in a scoreboard so decode can stall on not-yet-returned operands. Exposes the value currently being written, so decode can bypass the register file's one-cycle synchronous read.

---
 rtl/core_pkg.sv | 9 +
 rtl/wb_scoreboard.sv | 44 ++++
 rtl/writeback_unit.sv | 103 ++++++++++
 tb/tb_writeback_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared integer-pipeline constants and types.
// Used by writeback and later pipeline stages.
package core_pkg;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per register, two read ports.
// Latency: set/clear visible on busy outputs the cycle after the edge; no backpressure.
module wb_scoreboard
    import core_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_vld,
    input  reg_idx_t set_idx,
    input  logic     clr_vld,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1i,
    input  reg_idx_t rs2i,
    output logic     busy1,
    output logic     busy2
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear so a same-index issue in the retire cycle survives.
    always_comb begin
        pending_d = pending_q;
        if (clr_vld) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_vld && set_idx != '0) begin
            pending_d[set_idx] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign busy1 = pending_q[rs1i];
    assign busy2 = pending_q[rs2i];

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port arbiter (mem over ALU, ALU after STARVE_LIMIT stalls) with load scoreboard.
// Latency: acceptance at edge N drives reg_write/rdi/write_data during cycle N+1.
// Backpressure: ready is combinational from valids and state; the losing source holds until accepted.
module writeback_unit
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  reg_idx_t        alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  reg_idx_t        mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            load_issue,
    input  reg_idx_t        load_issue_rd,
    input  reg_idx_t        rs1i,
    input  reg_idx_t        rs2i,
    output logic            busy1,
    output logic            busy2,
    output reg_idx_t        rdi,
    output logic [XLEN-1:0] write_data,
    output logic            reg_write
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    reg_idx_t         rdi_q, rdi_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;
    logic             reg_write_q, reg_write_d;
    logic             alu_turn;
    logic             mem_fire, alu_fire;

    assign alu_turn  = alu_valid && (starve_cnt_q == STARVE_MAX);
    assign mem_ready = !rst && mem_valid && !alu_turn;
    assign alu_ready = !rst && alu_valid && !mem_ready;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_fire) begin
            starve_cnt_d = '0;
        end else if (alu_valid && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // x0 writes still move rdi/write_data; only the enable is suppressed.
    always_comb begin
        rdi_d        = rdi_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (mem_fire) begin
            rdi_d        = mem_rd;
            write_data_d = mem_data;
            reg_write_d  = (mem_rd != '0);
        end else if (alu_fire) begin
            rdi_d        = alu_rd;
            write_data_d = alu_data;
            reg_write_d  = (alu_rd != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rdi_q        <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rdi_q        <= rdi_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign rdi        = rdi_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;

    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_vld (load_issue),
        .set_idx (load_issue_rd),
        .clr_vld (mem_fire),
        .clr_idx (mem_rd),
        .rs1i    (rs1i),
        .rs2i    (rs2i),
        .busy1   (busy1),
        .busy2   (busy2)
    );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector bench for writeback_unit: per-cycle stimulus with hand-computed expectations.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, load_issue;
    logic [4:0]  alu_rd, mem_rd, load_issue_rd, rs1i, rs2i;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, busy1, busy2, reg_write;
    logic [4:0]  rdi;
    logic [31:0] write_data;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    writeback_unit #(.STARVE_LIMIT(4), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .load_issue    (load_issue),
        .load_issue_rd (load_issue_rd),
        .rs1i          (rs1i),
        .rs2i          (rs2i),
        .busy1         (busy1),
        .busy2         (busy2),
        .rdi           (rdi),
        .write_data    (write_data),
        .reg_write     (reg_write)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        li;
        logic [4:0]  lrd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ar;
        logic        e_mr;
        logic        e_b1;
        logic        e_b2;
        logic        e_we;
        logic [4:0]  e_rdi;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s step %0d: got %h, want %h", nm, row, act, exp);
        end
    endtask

    // Drive at negedge, check combinational outputs before the edge, registered outputs after it.
    task automatic step(input int row, input vec_t v);
        @(negedge clk);
        rst           = v.rst;
        alu_valid     = v.av;
        alu_rd        = v.ard;
        alu_data      = v.ad;
        mem_valid     = v.mv;
        mem_rd        = v.mrd;
        mem_data      = v.md;
        load_issue    = v.li;
        load_issue_rd = v.lrd;
        rs1i          = v.rs1;
        rs2i          = v.rs2;
        #1;
        chk("alu_ready", row, {31'b0, alu_ready}, {31'b0, v.e_ar});
        chk("mem_ready", row, {31'b0, mem_ready}, {31'b0, v.e_mr});
        chk("busy1", row, {31'b0, busy1}, {31'b0, v.e_b1});
        chk("busy2", row, {31'b0, busy2}, {31'b0, v.e_b2});
        @(posedge clk);
        #1;
        chk("reg_write", row, {31'b0, reg_write}, {31'b0, v.e_we});
        chk("rdi", row, {27'b0, rdi}, {27'b0, v.e_rdi});
        chk("write_data", row, write_data, v.e_wd);
    endtask

    function automatic vec_t mk(
        input logic rs, input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic li, input logic [4:0] lrd, input logic [4:0] r1, input logic [4:0] r2,
        input logic ear, input logic emr, input logic eb1, input logic eb2,
        input logic ewe, input logic [4:0] erdi, input logic [31:0] ewd);
        vec_t v;
        v.rst = rs; v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md; v.li = li; v.lrd = lrd;
        v.rs1 = r1; v.rs2 = r2;
        v.e_ar = ear; v.e_mr = emr; v.e_b1 = eb1; v.e_b2 = eb2;
        v.e_we = ewe; v.e_rdi = erdi; v.e_wd = ewd;
        return v;
    endfunction

    initial begin
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; load_issue = 1'b0;
        alu_rd = '0; mem_rd = '0; load_issue_rd = '0; rs1i = '0; rs2i = '0;
        alu_data = '0; mem_data = '0;

        //                rst av ard ad            mv mrd md           li lrd rs1 rs2  ar mr b1 b2  we rdi wd
        vecs[0]  = mk(1, 1, 3, 32'h11,        1, 4, 32'h22,       0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  32'h0);
        vecs[1]  = mk(0, 1, 5, 32'hDEADBEEF,  0, 0, 32'h0,        0, 0,  0,  0,  1, 0, 0, 0,  1, 5,  32'hDEADBEEF);
        vecs[2]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 7,  7,  0,  0, 0, 0, 0,  0, 5,  32'hDEADBEEF);
        vecs[3]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0,  7,  0,  0, 0, 1, 0,  0, 5,  32'hDEADBEEF);
        vecs[4]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0,  7,  0,  0, 0, 1, 0,  0, 5,  32'hDEADBEEF);
        vecs[5]  = mk(0, 0, 0, 32'h0,         1, 7, 32'h1234,     0, 0,  7,  0,  0, 1, 1, 0,  1, 7,  32'h1234);
        vecs[6]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0,  7,  0,  0, 0, 0, 0,  0, 7,  32'h1234);
        vecs[7]  = mk(0, 1, 0, 32'hCAFE,      0, 0, 32'h0,        1, 0,  0,  0,  1, 0, 0, 0,  0, 0,  32'hCAFE);
        vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  32'hCAFE);
        vecs[9]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 9,  0,  9,  0, 0, 0, 0,  0, 0,  32'hCAFE);
        vecs[10] = mk(0, 0, 0, 32'h0,         1, 9, 32'h99,       1, 9,  0,  9,  0, 1, 0, 1,  1, 9,  32'h99);
        vecs[11] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0,  0,  9,  0, 0, 0, 1,  0, 9,  32'h99);
        vecs[12] = mk(0, 0, 0, 32'h0,         1, 9, 32'h55,       0, 0,  9,  9,  0, 1, 1, 1,  1, 9,  32'h55);
        vecs[13] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0,  9,  9,  0, 0, 0, 0,  0, 9,  32'h55);
        vecs[14] = mk(0, 1, 3, 32'h33,        0, 0, 32'h0,        1, 12, 12, 0,  1, 0, 0, 0,  1, 3,  32'h33);
        vecs[15] = mk(1, 0, 0, 32'h0,         1, 12, 32'h77,      0, 0,  12, 0,  0, 0, 1, 0,  0, 0,  32'h0);
        vecs[16] = mk(0, 0, 0, 32'h0,         1, 12, 32'h77,      0, 0,  12, 0,  0, 1, 0, 0,  1, 12, 32'h77);

        for (int i = 0; i < 17; i++) begin
            step(i, vecs[i]);
        end

        // Both sources held valid: four mem wins, then one forced ALU win, repeating.
        for (int k = 0; k < 10; k++) begin
            logic m;
            m = (k % 5) != 4;
            step(100 + k, mk(0, 1, 1, 32'hA1A1, 1, 2, 32'hB2B2, 0, 0, 0, 0,
                             !m, m, 0, 0, 1, m ? 5'd2 : 5'd1, m ? 32'hB2B2 : 32'hA1A1));
        end

        // Idle cycle after the ALU win: no write and both readies low.
        step(200, mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA1A1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
